uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_cnt.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, FSM encoding and frame lengths.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit to each frame.
package uart_pkg;

   localparam int DATA_BITS  = 8;
   localparam int BAUD_CNT_W = 16;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_e;
`else
   localparam int FRAME_BITS = 10;
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_e;
`endif

   typedef enum logic {SRC_CPU, SRC_ECHO} src_e;

   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time down-counter: load restarts a bit period, tick marks its last cycle.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 10417
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic tick
);

   localparam logic [BAUD_CNT_W-1:0] RELOAD = BAUD_CNT_W'(BAUD_DIV - 1);

   logic [BAUD_CNT_W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= RELOAD;
      end else if (cnt != '0) begin
         cnt <= cnt - BAUD_CNT_W'(1);
      end
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-source round-robin arbiter feeding an 8N1 UART transmitter.
// Build option: UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 10417
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cpu_req,
   input  logic [7:0] cpu_data,
   output logic       cpu_gnt,
   input  logic       echo_req,
   input  logic [7:0] echo_data,
   output logic       echo_gnt,
   output logic       busy,
   output logic       uart_tx
);

   tx_state_e      state;
   src_e           last_src;
   logic [7:0]     data_q;
   logic [2:0]     bit_idx;
   logic           tick;
   logic           load;
   logic           start_frame;
   logic           pick_cpu;

   assign start_frame = (state == ST_IDLE) && (cpu_req || echo_req);
   // CPU wins unless echo is also asking and the CPU was served last.
   assign pick_cpu    = cpu_req && (!echo_req || last_src == SRC_ECHO);

   // NOTE: load gets a default before any conditional update, so no latch is inferred.
   always_comb begin
      load = start_frame;
      if (tick && state != ST_IDLE && state != ST_STOP) begin
         load = 1'b1;
      end
   end

   uart_baud_cnt #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud_cnt (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         last_src <= SRC_ECHO;
         data_q   <= '0;
         bit_idx  <= '0;
         cpu_gnt  <= 1'b0;
         echo_gnt <= 1'b0;
         busy     <= 1'b0;
         uart_tx  <= LINE_IDLE;
      end else begin
         cpu_gnt  <= 1'b0;
         echo_gnt <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_frame) begin
                  state   <= ST_START;
                  busy    <= 1'b1;
                  uart_tx <= START_BIT;
                  bit_idx <= '0;
                  if (pick_cpu) begin
                     cpu_gnt  <= 1'b1;
                     data_q   <= cpu_data;
                     last_src <= SRC_CPU;
                  end else begin
                     echo_gnt <= 1'b1;
                     data_q   <= echo_data;
                     last_src <= SRC_ECHO;
                  end
               end
            end
            ST_START: begin
               if (tick) begin
                  state   <= ST_DATA;
                  uart_tx <= data_q[0];
               end
            end
            ST_DATA: begin
               if (tick) begin
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state   <= ST_PARITY;
                     uart_tx <= even_parity(data_q);
`else
                     state   <= ST_STOP;
                     uart_tx <= STOP_BIT;
`endif
                  end else begin
                     uart_tx <= data_q[bit_idx + 3'd1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (tick) begin
                  state   <= ST_STOP;
                  uart_tx <= STOP_BIT;
               end
            end
`endif
            ST_STOP: begin
               if (tick) begin
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
                  uart_tx <= LINE_IDLE;
               end
            end
            default: begin
               state   <= ST_IDLE;
               busy    <= 1'b0;
               uart_tx <= LINE_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: BAUD_DIV=4 main instance, BAUD_DIV=2 second instance.
// Parity scenarios run only when UART_TX_PARITY_EN is defined.
module tb_uart_tx_arbiter;

`ifdef UART_TX_PARITY_EN
   localparam int  FRAME_BITS = 11;
   localparam bit  PARITY_ON  = 1'b1;
`else
   localparam int  FRAME_BITS = 10;
   localparam bit  PARITY_ON  = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;

   logic       cpu_req, echo_req, cpu_gnt, echo_gnt, busy, uart_tx;
   logic [7:0] cpu_data, echo_data;

   logic       cpu_req2, echo_req2, cpu_gnt2, echo_gnt2, busy2, uart_tx2;
   logic [7:0] cpu_data2, echo_data2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.BAUD_DIV(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_data  (cpu_data),
      .cpu_gnt   (cpu_gnt),
      .echo_req  (echo_req),
      .echo_data (echo_data),
      .echo_gnt  (echo_gnt),
      .busy      (busy),
      .uart_tx   (uart_tx)
   );

   uart_tx_arbiter #(.BAUD_DIV(2)) dut2 (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req2),
      .cpu_data  (cpu_data2),
      .cpu_gnt   (cpu_gnt2),
      .echo_req  (echo_req2),
      .echo_data (echo_data2),
      .echo_gnt  (echo_gnt2),
      .busy      (busy2),
      .uart_tx   (uart_tx2)
   );

   // Expected line level during bit-time k of a frame carrying d.
   function automatic logic bit_at(input logic [7:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
      if (PARITY_ON && k == 9) return ^d;
      return 1'b1;
   endfunction

   // Called at the negedge of the first START cycle; returns at the negedge of the idle cycle.
   task automatic check_frame(input string name, input int sel, input int div,
                              input logic exp_cpu, input logic [7:0] data,
                              input logic drop, input int echo_pulse_at);
      logic tx, bz, cg, eg, exp_tx, exp_cg, exp_eg;
      for (int c = 0; c < FRAME_BITS * div; c++) begin
         tx = (sel == 0) ? uart_tx  : uart_tx2;
         bz = (sel == 0) ? busy     : busy2;
         cg = (sel == 0) ? cpu_gnt  : cpu_gnt2;
         eg = (sel == 0) ? echo_gnt : echo_gnt2;
         exp_tx = bit_at(data, c / div);
         exp_cg = (c == 0) && exp_cpu;
         exp_eg = (c == 0) && !exp_cpu;
         n_tests++;
         if (tx !== exp_tx || bz !== 1'b1 || cg !== exp_cg || eg !== exp_eg) begin
            n_fail++;
            $display("FAIL %s cycle %0d: tx=%b busy=%b cpu_gnt=%b echo_gnt=%b, expected tx=%b busy=1 cpu_gnt=%b echo_gnt=%b",
                     name, c, tx, bz, cg, eg, exp_tx, exp_cg, exp_eg);
         end
         if (c == 0 && drop) begin
            if (sel == 0) begin
               cpu_req  = 1'b0;
               echo_req = 1'b0;
            end else begin
               cpu_req2 = 1'b0;
            end
         end
         if (c == echo_pulse_at)     echo_req = 1'b1;
         if (c == echo_pulse_at + 3) echo_req = 1'b0;
         @(negedge clk);
      end
      tx = (sel == 0) ? uart_tx  : uart_tx2;
      bz = (sel == 0) ? busy     : busy2;
      cg = (sel == 0) ? cpu_gnt  : cpu_gnt2;
      eg = (sel == 0) ? echo_gnt : echo_gnt2;
      n_tests++;
      if (tx !== 1'b1 || bz !== 1'b0 || cg !== 1'b0 || eg !== 1'b0) begin
         n_fail++;
         $display("FAIL %s idle gap: tx=%b busy=%b cpu_gnt=%b echo_gnt=%b, expected tx=1 busy=0 gnts=0",
                  name, tx, bz, cg, eg);
      end
   endtask

   task automatic check_idle(input string name, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         n_tests++;
         if (uart_tx !== 1'b1 || busy !== 1'b0 || cpu_gnt !== 1'b0 || echo_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL %s cycle %0d: tx=%b busy=%b cpu_gnt=%b echo_gnt=%b, expected tx=1 busy=0 gnts=0",
                     name, c, uart_tx, busy, cpu_gnt, echo_gnt);
         end
         @(negedge clk);
      end
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (uart_tx !== 1'b1 || busy !== 1'b0 || cpu_gnt !== 1'b0 || echo_gnt !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_dut: tx=%b busy=%b cpu_gnt=%b echo_gnt=%b, expected 1 0 0 0",
                  uart_tx, busy, cpu_gnt, echo_gnt);
      end
      n_tests++;
      if (uart_tx2 !== 1'b1 || busy2 !== 1'b0 || cpu_gnt2 !== 1'b0 || echo_gnt2 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_dut2: tx=%b busy=%b cpu_gnt=%b echo_gnt=%b, expected 1 0 0 0",
                  uart_tx2, busy2, cpu_gnt2, echo_gnt2);
      end
      reset = 1'b1;
      @(negedge clk);
      check_idle("reset_release", 4);
   endtask

   task automatic test_single();
      cpu_data = 8'hA5;
      cpu_req  = 1'b1;
      @(negedge clk);
      check_frame("single_a5", 0, 4, 1'b1, 8'hA5, 1'b1, -10);
      @(negedge clk);
      check_idle("single_after", 8);
   endtask

   task automatic test_round_robin();
      apply_reset();
      cpu_data  = 8'h11;
      echo_data = 8'h22;
      cpu_req   = 1'b1;
      echo_req  = 1'b1;
      @(negedge clk);
      check_frame("rr_frame1_cpu", 0, 4, 1'b1, 8'h11, 1'b0, -10);
      @(negedge clk);
      check_frame("rr_frame2_echo", 0, 4, 1'b0, 8'h22, 1'b0, -10);
      @(negedge clk);
      check_frame("rr_frame3_cpu", 0, 4, 1'b1, 8'h11, 1'b1, -10);
      @(negedge clk);
      check_idle("rr_after", 8);
   endtask

   task automatic test_echo_while_busy();
      cpu_data  = 8'h3C;
      echo_data = 8'h55;
      cpu_req   = 1'b1;
      @(negedge clk);
      check_frame("echo_busy", 0, 4, 1'b1, 8'h3C, 1'b1, 10);
      @(negedge clk);
      check_idle("echo_busy_after", 12);
   endtask

   task automatic test_reset_mid_frame();
      cpu_data = 8'h00;
      cpu_req  = 1'b1;
      @(negedge clk);
      cpu_req = 1'b0;
      repeat (17) @(negedge clk);
      n_tests++;
      if (uart_tx !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_bit3: tx=%b busy=%b, expected tx=0 busy=1", uart_tx, busy);
      end
      #1 reset = 1'b0;
      #1;
      n_tests++;
      if (uart_tx !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_async: tx=%b busy=%b, expected tx=1 busy=0", uart_tx, busy);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_idle("midreset_after", 50);
   endtask

   task automatic test_baud2();
      cpu_data2 = 8'hFF;
      cpu_req2  = 1'b1;
      @(negedge clk);
      check_frame("baud2_frame1", 1, 2, 1'b1, 8'hFF, 1'b0, -10);
      @(negedge clk);
      check_frame("baud2_frame2", 1, 2, 1'b1, 8'hFF, 1'b1, -10);
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      cpu_data = 8'h07;
      cpu_req  = 1'b1;
      @(negedge clk);
      check_frame("parity_07", 0, 4, 1'b1, 8'h07, 1'b1, -10);
      @(negedge clk);
      cpu_data = 8'h03;
      cpu_req  = 1'b1;
      @(negedge clk);
      check_frame("parity_03", 0, 4, 1'b1, 8'h03, 1'b1, -10);
      @(negedge clk);
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b0;
      cpu_req    = 1'b0;
      echo_req   = 1'b0;
      cpu_data   = 8'h00;
      echo_data  = 8'h00;
      cpu_req2   = 1'b0;
      echo_req2  = 1'b0;
      cpu_data2  = 8'h00;
      echo_data2 = 8'h00;
      @(negedge clk);
      test_reset();
      test_single();
      test_round_robin();
      test_echo_while_busy();
      test_reset_mid_frame();
      test_baud2();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
